connect4_board_ctrl: RTL and testbench
======================================

Name: connect4_board_ctrl

Overview:
- Owns the Connect-4 board state and the turn sequence.
- Accepts a column choice from the human player or from the PvE bot: one-hot column plus a confirm pulse.
- Drops the token into the lowest empty row using a per-row scan, then alternates turns.
- Drives `tokens` and `bot_turn` into the bot block, and consumes that block's `bot_move`/`bot_confirm`.

Parameters:
ROWS, 6, board rows; row 0 is the top row, row ROWS-1 is the bottom row.
COLS, 7, board columns; column c corresponds to one-hot bit c.
P1_CODE, 2'b01, cell code for player 1 (human).
P2_CODE, 2'b10, cell code for player 2 (human or bot); 2'b00 = empty.

Ports:
clock  in  1  system clock; all state on posedge.
reset  in  1  asynchronous, active-high; clears all state.
pve_mode  in  1  1 = player 2 is the bot; 0 = two humans.
new_game  in  1  synchronous clear of board/turn; 1-cycle pulse.
game_over  in  1  from win checker; while 1, no moves are accepted.
player_move  in  7  one-hot column from the human input.
player_confirm  in  1  1-cycle pulse; sample player_move.
bot_move  in  7  one-hot column from the bot; ignored unless bot_confirm=1.
bot_confirm  in  1  1-cycle pulse from the bot.
tokens  out  [1:0] x [ROWS][COLS]  board cells.
current_player  out  1  0 = P1 to move, 1 = P2 to move.
bot_turn  out  1  bot may move now.
move_done  out  1  1-cycle pulse: token written.
col_full_err  out  1  1-cycle pulse: move rejected (full column or bad one-hot).
board_full  out  1  42 tokens placed.
move_count  out  6  tokens placed, 0..42.

Behaviour:
- Reset (async):
  - all tokens = 2'b00; current_player = 0; state = WAIT.
  - move_count = 0; all pulses and bot_turn = 0.
- States: WAIT, SCAN.
- Active source in WAIT:
  - Human if pve_mode=0 or current_player=0; bot otherwise.
  - The confirm of the non-active source is ignored, including when both confirms arrive in the same cycle.
- WAIT → SCAN on an active confirm with game_over=0 and board_full=0:
  - Latch the column index; row_ptr = ROWS-1.
  - If the sampled move is not exactly one-hot: pulse col_full_err next cycle and stay in WAIT.
- SCAN, one row checked per clock:
  - tokens[row_ptr][col] == 00: write the current player code, toggle current_player, move_count++, pulse move_done, → WAIT.
  - Cell occupied and row_ptr == 0: pulse col_full_err, turn unchanged, → WAIT.
  - Cell occupied otherwise: row_ptr--.
- Latency: confirm sampled at edge E0; a column holding k tokens is written at edge E(1+k), k = 0..5. A full column errors at E6.
- bot_turn = pve_mode & current_player & (state == WAIT) & ~game_over & ~board_full.
  - Combinational from registers only.
  - Drops at the edge that accepts the bot confirm, which releases the bot's handshake.
  - Reasserts after a bot col_full_err so the bot retries.
- board_full = (move_count == ROWS*COLS).
- new_game has priority over everything; it behaves like reset but is synchronous. It aborts a SCAN in progress with no write and no pulse.
- Board integrity:
  - No cell ever changes from non-zero to any other value except by reset or new_game.
  - At most one cell is written per move.
- Confirms arriving while in SCAN are dropped; there is no queueing.
- Changes to pve_mode take effect only in WAIT.

Test Plan:
- pve_mode=0, P1 confirms col 3 (7'b0001000) → tokens[5][3] = 01 at E1, move_done, current_player = 1; P2 col 3 → tokens[4][3] = 10 at E2.
- Fill column 0 with 6 tokens, then confirm col 0 → col_full_err at E6, board unchanged, current_player unchanged, move_count = 6.
- pve_mode=1, P1 moves, then bot asserts bot_confirm with col 4:
  - bot_turn = 1 before the confirm and 0 after it.
  - tokens[5][4] = 10; current_player = 0.
  - player_confirm during the bot's turn is ignored.
- Non-one-hot move (7'b0011000) and bot_move = 7'd9 with bot_confirm → col_full_err, no write, turn held.
- new_game asserted mid-SCAN (column with 3 tokens) → board all zero next cycle, WAIT state, no move_done.
- Play 42 legal moves → board_full = 1, move_count = 42, bot_turn = 0, further confirms ignored; async reset mid-game clears everything without a clock edge.

Source files
------------

// File: rtl/connect4_board_ctrl.sv
// Connect-4 board owner: accepts human/bot column picks, drops tokens with a
// one-row-per-clock scan from the bottom, and alternates turns.
module connect4_board_ctrl #(
    parameter int         ROWS    = 6,
    parameter int         COLS    = 7,
    parameter logic [1:0] P1_CODE = 2'b01,
    parameter logic [1:0] P2_CODE = 2'b10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pve_mode,
    input  logic            new_game,
    input  logic            game_over,
    input  logic [COLS-1:0] player_move,
    input  logic            player_confirm,
    input  logic [COLS-1:0] bot_move,
    input  logic            bot_confirm,
    output logic [1:0]      tokens [ROWS][COLS],
    output logic            current_player,
    output logic            bot_turn,
    output logic            move_done,
    output logic            col_full_err,
    output logic            board_full,
    output logic [5:0]      move_count
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic {S_WAIT = 1'b0, S_SCAN = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [1:0]      r_tokens [ROWS][COLS];
    logic            r_player;
    logic            r_move_done;
    logic            r_col_err;
    logic [5:0]      r_count;

    logic            w_bot_active;
    logic            w_sel_confirm;
    logic [COLS-1:0] w_sel_move;
    logic            w_onehot;
    logic            w_accept;
    logic            w_scan;
    logic            w_cell_empty;
    logic            w_write;
    logic            w_scan_full;
    logic            w_err_pulse;
    logic            w_board_full;
    logic [CW-1:0]   w_col_idx;

    // Only the source whose turn it is can be heard; the other confirm is dropped.
    assign w_bot_active  = pve_mode & r_player;
    assign w_sel_confirm = w_bot_active ? bot_confirm : player_confirm;
    assign w_sel_move    = w_bot_active ? bot_move : player_move;
    assign w_onehot      = $onehot(w_sel_move);
    assign w_board_full  = (r_count == 6'(ROWS * COLS));
    assign w_scan        = (r_state == S_SCAN);
    assign w_accept      = (r_state == S_WAIT) & w_sel_confirm & ~game_over & ~w_board_full;
    assign w_cell_empty  = (r_tokens[r_row][r_col] == 2'b00);
    assign w_write       = w_scan & w_cell_empty;
    assign w_scan_full   = w_scan & ~w_cell_empty & (r_row == '0);

    always_comb begin
        w_col_idx = '0;
        for (int c = 0; c < COLS; c++) begin
            if (w_sel_move[c]) w_col_idx = CW'(c);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
        end else if (new_game) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT: if (w_accept && w_onehot) w_state_next = S_SCAN;
            S_SCAN: if (w_write || w_scan_full) w_state_next = S_WAIT;
            default: w_state_next = S_WAIT;
        endcase
    end

    always_comb begin
        w_err_pulse = (w_accept & ~w_onehot) | w_scan_full;
        bot_turn    = pve_mode & r_player & (r_state == S_WAIT) & ~game_over & ~w_board_full;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (new_game) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept && w_onehot) begin
            r_row <= RW'(ROWS - 1);
            r_col <= w_col_idx;
        end else if (w_scan && !w_cell_empty && r_row != '0) begin
            r_row <= r_row - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_player    <= 1'b0;
            r_count     <= '0;
            r_move_done <= 1'b0;
            r_col_err   <= 1'b0;
        end else if (new_game) begin
            r_player    <= 1'b0;
            r_count     <= '0;
            r_move_done <= 1'b0;
            r_col_err   <= 1'b0;
        end else begin
            r_move_done <= w_write;
            r_col_err   <= w_err_pulse;
            if (w_write) begin
                r_player <= ~r_player;
                r_count  <= r_count + 1'b1;
            end
        end
    end

    // Each cell is written only while empty, so a placed token can never change.
    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        r_tokens[gi][gj] <= 2'b00;
                    end else if (new_game) begin
                        r_tokens[gi][gj] <= 2'b00;
                    end else if (w_write && r_row == RW'(gi) && r_col == CW'(gj)) begin
                        r_tokens[gi][gj] <= r_player ? P2_CODE : P1_CODE;
                    end
                end
                assign tokens[gi][gj] = r_tokens[gi][gj];
            end
        end
    endgenerate

    assign current_player = r_player;
    assign move_done      = r_move_done;
    assign col_full_err   = r_col_err;
    assign board_full     = w_board_full;
    assign move_count     = r_count;

endmodule

// File: tb/tb_connect4_board_ctrl.sv
// Bench for connect4_board_ctrl: column-height reference model checked every
// cycle, directed scenarios with literal expectations, then random play.
module tb_connect4_board_ctrl;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pve_mode = 1'b0;
    logic       new_game = 1'b0;
    logic       game_over = 1'b0;
    logic [6:0] player_move = '0;
    logic       player_confirm = 1'b0;
    logic [6:0] bot_move = '0;
    logic       bot_confirm = 1'b0;
    logic [1:0] tokens [ROWS][COLS];
    logic       current_player;
    logic       bot_turn;
    logic       move_done;
    logic       col_full_err;
    logic       board_full;
    logic [5:0] move_count;

    connect4_board_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .pve_mode       (pve_mode),
        .new_game       (new_game),
        .game_over      (game_over),
        .player_move    (player_move),
        .player_confirm (player_confirm),
        .bot_move       (bot_move),
        .bot_confirm    (bot_confirm),
        .tokens         (tokens),
        .current_player (current_player),
        .bot_turn       (bot_turn),
        .move_done      (move_done),
        .col_full_err   (col_full_err),
        .board_full     (board_full),
        .move_count     (move_count)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: board of player codes, whose turn, token count, and a
    // countdown to the edge where a pending drop resolves.
    int mb [ROWS][COLS];
    bit mp = 1'b0;
    int mc = 0;
    int busy = 0;
    int pcol = 0;
    int pk = 0;
    bit mdone = 1'b0;
    bit merr = 1'b0;

    task automatic clear_model();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mb[r][c] = 0;
        mp = 1'b0; mc = 0; busy = 0; mdone = 1'b0; merr = 1'b0;
    endtask

    function automatic int height(input int c);
        int h = 0;
        for (int r = 0; r < ROWS; r++)
            if (mb[r][c] != 0) h++;
        return h;
    endfunction

    task automatic model_step();
        bit         conf;
        logic [6:0] mv;
        mdone = 1'b0;
        merr  = 1'b0;
        if (new_game) begin
            clear_model();
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                if (pk < ROWS) begin
                    mb[ROWS-1-pk][pcol] = mp ? 2 : 1;
                    mp = ~mp;
                    mc++;
                    mdone = 1'b1;
                end else begin
                    merr = 1'b1;
                end
            end
        end else begin
            conf = (pve_mode && mp) ? bot_confirm : player_confirm;
            mv   = (pve_mode && mp) ? bot_move : player_move;
            if (conf && !game_over && mc < ROWS * COLS) begin
                if ($countones(mv) == 1) begin
                    for (int c = 0; c < COLS; c++)
                        if (mv[c]) pcol = c;
                    pk   = height(pcol);
                    busy = (pk < ROWS) ? pk + 1 : ROWS;
                end else begin
                    merr = 1'b1;
                end
            end
        end
    endtask

    initial begin
        clear_model();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) clear_model();
            else model_step();
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int board_diff();
        int d = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (int'(tokens[r][c]) != mb[r][c]) d++;
        return d;
    endfunction

    function automatic int board_nonzero();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (tokens[r][c] != 2'b00) n++;
        return n;
    endfunction

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clock);
            check("board_cells_differing", board_diff(), 0);
            check("current_player", int'(current_player), int'(mp));
            check("move_count", int'(move_count), mc);
            check("board_full", int'(board_full), int'(mc == ROWS * COLS));
            check("move_done", int'(move_done), int'(mdone));
            check("col_full_err", int'(col_full_err), int'(merr));
            check("bot_turn", int'(bot_turn),
                  int'(pve_mode && mp && busy == 0 && !game_over && mc < ROWS * COLS));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic confirm(input bit bot, input logic [6:0] mv);
        if (bot) begin bot_move = mv; bot_confirm = 1'b1; end
        else begin player_move = mv; player_confirm = 1'b1; end
        tick();
        bot_confirm = 1'b0;
        player_confirm = 1'b0;
    endtask

    task automatic settle();
        repeat (8) tick();
    endtask

    task automatic start_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    function automatic logic [6:0] rand_move();
        logic [6:0] m;
        if ($urandom_range(0, 7) != 0) m = 7'(1 << $urandom_range(0, 6));
        else m = 7'($urandom_range(0, 127));
        return m;
    endfunction

    initial begin
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        check("reset_move_count", int'(move_count), 0);
        check("reset_player", int'(current_player), 0);
        check("reset_cells", board_nonzero(), 0);

        // Two humans drop into column 3.
        confirm(0, 7'b0001000);
        @(negedge clock);
        check("p1_e0_cell53", int'(tokens[5][3]), 0);
        @(negedge clock);
        check("p1_e1_cell53", int'(tokens[5][3]), 1);
        check("p1_e1_move_done", int'(move_done), 1);
        check("p1_e1_player", int'(current_player), 1);
        confirm(0, 7'b0001000);
        @(negedge clock);
        @(negedge clock);
        check("p2_e1_cell43", int'(tokens[4][3]), 0);
        @(negedge clock);
        check("p2_e2_cell43", int'(tokens[4][3]), 2);

        // Full column error at E6.
        start_new_game();
        for (int i = 0; i < ROWS; i++) begin
            confirm(0, 7'b0000001);
            settle();
        end
        confirm(0, 7'b0000001);
        repeat (6) @(negedge clock);
        check("full_e5_err", int'(col_full_err), 0);
        @(negedge clock);
        check("full_e6_err", int'(col_full_err), 1);
        check("full_count", int'(move_count), 6);
        check("full_player", int'(current_player), 0);

        // PvE: human ignored on bot's turn, bot moves in column 4.
        start_new_game();
        pve_mode = 1'b1;
        confirm(0, 7'b0000001);
        settle();
        check("pve_bot_turn_on", int'(bot_turn), 1);
        confirm(0, 7'b0000100);
        settle();
        check("pve_human_ignored_count", int'(move_count), 1);
        check("pve_human_ignored_cell", int'(tokens[5][2]), 0);
        check("pve_bot_turn_before", int'(bot_turn), 1);
        confirm(1, 7'b0010000);
        check("pve_bot_turn_after", int'(bot_turn), 0);
        settle();
        check("pve_bot_cell54", int'(tokens[5][4]), 2);
        check("pve_player_back", int'(current_player), 0);

        // Bad one-hot from human, then from bot.
        pve_mode = 1'b0;
        confirm(0, 7'b0011000);
        @(negedge clock);
        check("bad_human_err", int'(col_full_err), 1);
        settle();
        check("bad_human_count", int'(move_count), 2);
        pve_mode = 1'b1;
        confirm(0, 7'b1000000);
        settle();
        confirm(1, 7'd9);
        @(negedge clock);
        check("bad_bot_err", int'(col_full_err), 1);
        check("bad_bot_retry", int'(bot_turn), 1);
        check("bad_bot_player", int'(current_player), 1);
        settle();

        // new_game aborts a scan over a 3-token column.
        pve_mode = 1'b0;
        start_new_game();
        for (int i = 0; i < 3; i++) begin
            confirm(0, 7'b0000010);
            settle();
        end
        confirm(0, 7'b0000010);
        tick();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        @(negedge clock);
        check("abort_cells", board_nonzero(), 0);
        check("abort_move_done", int'(move_done), 0);
        check("abort_count", int'(move_count), 0);
        settle();
        check("abort_no_late_write", board_nonzero(), 0);

        // Fill the board.
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) begin
                confirm(0, 7'(1 << c));
                settle();
            end
        pve_mode = 1'b1;
        @(negedge clock);
        check("filled_board_full", int'(board_full), 1);
        check("filled_count", int'(move_count), 42);
        check("filled_bot_turn", int'(bot_turn), 0);
        confirm(0, 7'b0000001);
        confirm(1, 7'b0000001);
        settle();
        check("filled_ignored_count", int'(move_count), 42);

        // Random play.
        pve_mode = 1'b0;
        start_new_game();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) pve_mode = ~pve_mode;
            new_game       = ($urandom_range(0, 299) == 0);
            game_over      = ($urandom_range(0, 15) == 0);
            player_confirm = ($urandom_range(0, 3) == 0);
            bot_confirm    = ($urandom_range(0, 3) == 0);
            player_move    = rand_move();
            bot_move       = rand_move();
            tick();
        end
        new_game = 1'b0; game_over = 1'b0;
        player_confirm = 1'b0; bot_confirm = 1'b0;
        settle();

        // Asynchronous reset mid-game clears without a clock edge.
        pve_mode = 1'b0;
        start_new_game();
        confirm(0, 7'b0100000);
        settle();
        confirm(0, 7'b0100000);
        settle();
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("async_cells", board_nonzero(), 0);
        check("async_count", int'(move_count), 0);
        check("async_player", int'(current_player), 0);
        tick();
        reset = 1'b0;
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
